// File: rtl/lmu_interpret_seq.sv
// Sequential LMU interpreter: scans NUM_LQ logical qubits LANES per cycle and emits the corrected measurement.
// Optional anticommute counter output enabled by defining LMU_ANTICOMM_CNT_EN.
module lmu_interpret_seq #(
   parameter int NUM_LQ = 8,
   parameter int LANES  = 2,
   parameter int CNT_W  = $clog2(NUM_LQ + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [2*NUM_LQ-1:0]   lpplist,
   input  logic [2*NUM_LQ-1:0]   byproduct,
   input  logic                  byproduct_check,
   input  logic                  byproduct_upd,
   input  logic                  meas_sign,
   input  logic                  init_meas,
   input  logic [NUM_LQ-1:0]     lqsignX_acc,
   input  logic [NUM_LQ-1:0]     lqsignZ_acc,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  final_meas,
   output logic [2*NUM_LQ-1:0]   byproduct_reg,
   input  logic                  a_valid,
   input  logic                  a_val,
   input  logic                  a_sign_load,
   input  logic                  a_sign,
   input  logic                  a_clear,
`ifdef LMU_ANTICOMM_CNT_EN
   output logic [CNT_W-1:0]      anticomm_cnt,
`endif
   output logic [1:0]            measfb_xorz
);

   localparam logic [1:0] PP_I = 2'b00;
   localparam logic [1:0] PP_X = 2'b01;
   localparam logic [1:0] PP_Z = 2'b10;
   localparam logic [1:0] PP_Y = 2'b11;
   localparam logic [1:0] FBXORZ_INVALID = 2'b00;
   localparam logic [1:0] FBXORZ_X       = 2'b01;
   localparam logic [1:0] FBXORZ_Z       = 2'b10;
   localparam logic       MEASSIGN_PLUS  = 1'b0;
   localparam logic       MEASSIGN_MINUS = 1'b1;
   localparam int unsigned NUM_LQ_U = NUM_LQ;
   localparam int unsigned LANES_U  = LANES;

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_e;

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      idx_q, idx_d;
   logic [2*NUM_LQ-1:0]   lpp_q, lpp_d, bp_q, bp_d, bpreg_q, bpreg_d;
   logic [NUM_LQ-1:0]     sx_q, sx_d, sz_q, sz_d;
   logic                  chk_q, chk_d, upd_q, upd_d, msign_q, msign_d, init_q, init_d;
   logic                  nc_q, nc_d, sgn_q, sgn_d;
   logic                  out_valid_q, out_valid_d, final_q, final_d;
   logic                  a_taken_q, a_taken_d, a_sign_q, a_sign_d;
   logic [1:0]            fb_q, fb_d;
   logic [NUM_LQ-1:0]     anti_vec, sgn_vec, lane_en;
   logic                  last_lane;
`ifdef LMU_ANTICOMM_CNT_EN
   logic [CNT_W-1:0]      cnt_q, cnt_d, acnt_q, acnt_d;
   int unsigned           cnt_sum;
`endif

   // Per-qubit anticommute and sign contributions from the captured request.
   for (genvar g = 0; g < NUM_LQ; g++) begin : g_qubit
      localparam int unsigned GU = g;
      logic [1:0] lpp, bpp;
      assign lpp = lpp_q[2*g +: 2];
      assign bpp = bp_q[2*g +: 2];
      assign anti_vec[g] = (lpp != bpp) && (lpp != PP_I) && (bpp != PP_I);
      assign sgn_vec[g]  = (lpp == PP_X) ? sx_q[g] :
                           (lpp == PP_Z) ? sz_q[g] :
                           (lpp == PP_Y) ? (sx_q[g] ^ sz_q[g]) : 1'b0;
      assign lane_en[g]  = (GU >= 32'(idx_q)) && (GU < 32'(idx_q) + LANES_U);
   end

   assign last_lane = (32'(idx_q) + LANES_U) >= NUM_LQ_U;

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      lpp_d       = lpp_q;
      bp_d        = bp_q;
      sx_d        = sx_q;
      sz_d        = sz_q;
      chk_d       = chk_q;
      upd_d       = upd_q;
      msign_d     = msign_q;
      init_d      = init_q;
      nc_d        = nc_q;
      sgn_d       = sgn_q;
      out_valid_d = out_valid_q;
      final_d     = final_q;
      bpreg_d     = bpreg_q;
`ifdef LMU_ANTICOMM_CNT_EN
      cnt_d       = cnt_q;
      acnt_d      = acnt_q;
      cnt_sum     = 32'(cnt_q) + 32'($countones(anti_vec & lane_en));
`endif
      unique case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               lpp_d   = lpplist;
               bp_d    = byproduct;
               sx_d    = lqsignX_acc;
               sz_d    = lqsignZ_acc;
               chk_d   = byproduct_check;
               upd_d   = byproduct_upd;
               msign_d = meas_sign;
               init_d  = init_meas;
               nc_d    = 1'b0;
               sgn_d   = 1'b0;
               idx_d   = '0;
`ifdef LMU_ANTICOMM_CNT_EN
               cnt_d   = '0;
`endif
               state_d = S_SCAN;
            end
         end
         S_SCAN: begin
            nc_d  = nc_q ^ (^(anti_vec & lane_en));
            sgn_d = sgn_q ^ (^(sgn_vec & lane_en));
`ifdef LMU_ANTICOMM_CNT_EN
            cnt_d = (cnt_sum > NUM_LQ_U) ? CNT_W'(NUM_LQ) : CNT_W'(cnt_sum);
`endif
            // The last scan cycle also performs the DONE-entry work so out_valid rises with the state change.
            if (last_lane) begin
               state_d     = S_DONE;
               out_valid_d = 1'b1;
               final_d     = (nc_d & chk_q) ^ sgn_d ^ msign_q ^ init_q;
               if (upd_q) bpreg_d = bpreg_q ^ bp_q;
`ifdef LMU_ANTICOMM_CNT_EN
               acnt_d      = cnt_d;
`endif
            end else begin
               idx_d = idx_q + CNT_W'(LANES);
            end
         end
         S_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      a_taken_d = a_taken_q;
      a_sign_d  = a_sign_load ? a_sign : a_sign_q;
      fb_d      = FBXORZ_INVALID;
      if (a_clear) begin
         a_taken_d = 1'b0;
      end else if (a_valid && !a_taken_q) begin
         a_taken_d = 1'b1;
         fb_d      = (a_val != (a_sign_q == MEASSIGN_MINUS)) ? FBXORZ_X : FBXORZ_Z;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         lpp_q       <= '0;
         bp_q        <= '0;
         sx_q        <= '0;
         sz_q        <= '0;
         chk_q       <= 1'b0;
         upd_q       <= 1'b0;
         msign_q     <= 1'b0;
         init_q      <= 1'b0;
         nc_q        <= 1'b0;
         sgn_q       <= 1'b0;
         out_valid_q <= 1'b0;
         final_q     <= 1'b0;
         bpreg_q     <= '0;
         a_taken_q   <= 1'b0;
         a_sign_q    <= MEASSIGN_PLUS;
         fb_q        <= FBXORZ_INVALID;
`ifdef LMU_ANTICOMM_CNT_EN
         cnt_q       <= '0;
         acnt_q      <= '0;
`endif
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         lpp_q       <= lpp_d;
         bp_q        <= bp_d;
         sx_q        <= sx_d;
         sz_q        <= sz_d;
         chk_q       <= chk_d;
         upd_q       <= upd_d;
         msign_q     <= msign_d;
         init_q      <= init_d;
         nc_q        <= nc_d;
         sgn_q       <= sgn_d;
         out_valid_q <= out_valid_d;
         final_q     <= final_d;
         bpreg_q     <= bpreg_d;
         a_taken_q   <= a_taken_d;
         a_sign_q    <= a_sign_d;
         fb_q        <= fb_d;
`ifdef LMU_ANTICOMM_CNT_EN
         cnt_q       <= cnt_d;
         acnt_q      <= acnt_d;
`endif
      end
   end

   assign in_ready      = (state_q == S_IDLE);
   assign out_valid     = out_valid_q;
   assign final_meas    = final_q;
   assign byproduct_reg = bpreg_q;
   assign measfb_xorz   = fb_q;
`ifdef LMU_ANTICOMM_CNT_EN
   assign anticomm_cnt  = acnt_q;
`endif

endmodule

// File: tb/tb_lmu_interpret_seq.sv
// Directed bench for lmu_interpret_seq: NUM_LQ=8/LANES=2 and NUM_LQ=5/LANES=2 instances.
module tb_lmu_interpret_seq;

   localparam logic [1:0] FB_INV = 2'b00;
   localparam logic [1:0] FB_X   = 2'b01;
   localparam logic [1:0] FB_Z   = 2'b10;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, in_valid, in_ready, chk_in, upd_in, ms_in, im_in;
   logic [15:0] lpplist, byproduct, bpreg;
   logic [7:0]  sx_in, sz_in;
   logic        out_valid, out_ready, final_meas;
   logic        a_valid, a_val, a_sign_load, a_sign, a_clear;
   logic [1:0]  measfb;

   logic        rst5_n, in_valid5, in_ready5, chk5, upd5, ms5, im5;
   logic [9:0]  lpp5, bp5, bpreg5;
   logic [4:0]  sx5, sz5;
   logic        out_valid5, out_ready5, final5;
   logic        a_valid5, a_val5, a_sign_load5, a_sign5, a_clear5;
   logic [1:0]  measfb5;
`ifdef LMU_ANTICOMM_CNT_EN
   logic [3:0]  cnt8;
   logic [2:0]  cnt5;
`endif

   lmu_interpret_seq #(.NUM_LQ(8), .LANES(2)) u8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .lpplist(lpplist), .byproduct(byproduct), .byproduct_check(chk_in),
      .byproduct_upd(upd_in), .meas_sign(ms_in), .init_meas(im_in),
      .lqsignX_acc(sx_in), .lqsignZ_acc(sz_in), .out_valid(out_valid),
      .out_ready(out_ready), .final_meas(final_meas), .byproduct_reg(bpreg),
      .a_valid(a_valid), .a_val(a_val), .a_sign_load(a_sign_load), .a_sign(a_sign),
      .a_clear(a_clear),
`ifdef LMU_ANTICOMM_CNT_EN
      .anticomm_cnt(cnt8),
`endif
      .measfb_xorz(measfb));

   lmu_interpret_seq #(.NUM_LQ(5), .LANES(2)) u5 (
      .clk(clk), .rst_n(rst5_n), .in_valid(in_valid5), .in_ready(in_ready5),
      .lpplist(lpp5), .byproduct(bp5), .byproduct_check(chk5),
      .byproduct_upd(upd5), .meas_sign(ms5), .init_meas(im5),
      .lqsignX_acc(sx5), .lqsignZ_acc(sz5), .out_valid(out_valid5),
      .out_ready(out_ready5), .final_meas(final5), .byproduct_reg(bpreg5),
      .a_valid(a_valid5), .a_val(a_val5), .a_sign_load(a_sign_load5), .a_sign(a_sign5),
      .a_clear(a_clear5),
`ifdef LMU_ANTICOMM_CNT_EN
      .anticomm_cnt(cnt5),
`endif
      .measfb_xorz(measfb5));

   typedef struct {
      string       name;
      logic [15:0] lpp;
      logic [15:0] bp;
      logic        chk;
      logic        upd;
      logic        ms;
      logic        im;
      logic [7:0]  sx;
      logic [7:0]  sz;
      logic        exp;
   } vec_t;

   int checks = 0;
   int passed = 0;
   logic [15:0] exp_bp = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic run8(input vec_t v, input int hold);
      int lat;
      @(negedge clk);
      check({v.name, " in_ready"}, 32'(in_ready), 32'd1);
      lpplist = v.lpp; byproduct = v.bp; chk_in = v.chk; upd_in = v.upd;
      ms_in = v.ms; im_in = v.im; sx_in = v.sx; sz_in = v.sz; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lpplist = ~v.lpp; byproduct = ~v.bp; chk_in = ~v.chk; upd_in = ~v.upd;
      ms_in = ~v.ms; im_in = ~v.im; sx_in = ~v.sx; sz_in = ~v.sz;
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      if (v.upd) exp_bp ^= v.bp;
      check({v.name, " latency"}, 32'(lat), 32'd5);
      check({v.name, " final"}, 32'(final_meas), 32'(v.exp));
      check({v.name, " bpreg"}, 32'(bpreg), 32'(exp_bp));
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         check({v.name, " hold"}, {29'd0, out_valid, final_meas, in_ready}, {29'd0, 1'b1, v.exp, 1'b0});
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({v.name, " release"}, {30'd0, out_valid, in_ready}, 32'd1);
   endtask

   task automatic run5(input string name, input logic [9:0] lpp, input logic [9:0] bp,
                       input logic chk, input logic upd, input logic [4:0] sx,
                       input logic [4:0] sz, input logic exp, input logic [9:0] ebp);
      int lat;
      @(negedge clk);
      lpp5 = lpp; bp5 = bp; chk5 = chk; upd5 = upd; sx5 = sx; sz5 = sz;
      ms5 = 1'b0; im5 = 1'b0; in_valid5 = 1'b1;
      @(posedge clk); #1;
      in_valid5 = 1'b0; lpp5 = ~lpp; bp5 = ~bp;
      lat = 1;
      while (!out_valid5 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check({name, " latency"}, 32'(lat), 32'd4);
      check({name, " final"}, 32'(final5), 32'(exp));
      check({name, " bpreg"}, 32'(bpreg5), 32'(ebp));
      out_ready5 = 1'b1;
      @(posedge clk); #1;
      out_ready5 = 1'b0;
   endtask

   initial begin
      vec_t vecs[9];
      vec_t vhold;
      int first, second, pulses;

      vecs[0] = '{"all_I",     16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1};
      vecs[1] = '{"XvsZ_chk",  16'h0001, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1};
      vecs[2] = '{"XvsZ_nchk", 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0};
      vecs[3] = '{"Y_upd1",    16'h00C0, 16'h0040, 1'b0, 1'b1, 1'b0, 1'b0, 8'h08, 8'h00, 1'b1};
      vecs[4] = '{"Y_upd2",    16'h00C0, 16'h0040, 1'b0, 1'b1, 1'b0, 1'b0, 8'h08, 8'h00, 1'b1};
      vecs[5] = '{"Y_chk",     16'h00C0, 16'h0040, 1'b1, 1'b0, 1'b0, 1'b0, 8'h08, 8'h00, 1'b0};
      vecs[6] = '{"ZeqZ_q7",   16'h8000, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h80, 1'b0};
      vecs[7] = '{"three_anti",16'h0015, 16'h013F, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0};
      vecs[8] = '{"Z_q6",      16'h2000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h40, 8'h40, 1'b1};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      lpplist = '0; byproduct = '0; chk_in = 1'b0; upd_in = 1'b0; ms_in = 1'b0; im_in = 1'b0;
      sx_in = '0; sz_in = '0;
      a_valid = 1'b0; a_val = 1'b0; a_sign_load = 1'b0; a_sign = 1'b0; a_clear = 1'b0;
      rst5_n = 1'b0; in_valid5 = 1'b0; out_ready5 = 1'b0;
      lpp5 = '0; bp5 = '0; chk5 = 1'b0; upd5 = 1'b0; ms5 = 1'b0; im5 = 1'b0; sx5 = '0; sz5 = '0;
      a_valid5 = 1'b0; a_val5 = 1'b0; a_sign_load5 = 1'b0; a_sign5 = 1'b0; a_clear5 = 1'b0;

      #12;
      check("rst in_ready", 32'(in_ready), 32'd1);
      check("rst out_valid", 32'(out_valid), 32'd0);
      check("rst final", 32'(final_meas), 32'd0);
      check("rst bpreg", 32'(bpreg), 32'd0);
      check("rst measfb", 32'(measfb), 32'(FB_INV));
      @(negedge clk);
      rst_n = 1'b1; rst5_n = 1'b1;

      for (int i = 0; i < 9; i++) run8(vecs[i], 0);

      vhold = '{"hold", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1};
      run8(vhold, 10);

      // Back-to-back throughput with out_ready held high.
      @(negedge clk);
      lpplist = '0; byproduct = '0; chk_in = 1'b0; upd_in = 1'b0; ms_in = 1'b0; im_in = 1'b0;
      sx_in = '0; sz_in = '0; in_valid = 1'b1; out_ready = 1'b1;
      first = -1; second = -1;
      for (int c = 0; c < 14; c++) begin
         if (in_ready) begin
            if (first < 0) first = c;
            else if (second < 0) second = c;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      repeat (10) @(negedge clk);
      out_ready = 1'b0;
      check("throughput", 32'(second - first), 32'd6);
      check("drain idle", {30'd0, out_valid, in_ready}, 32'd1);

      // Feedback path.
      @(negedge clk);
      a_sign = 1'b1; a_sign_load = 1'b1;
      @(posedge clk); #1;
      check("fb idle", 32'(measfb), 32'(FB_INV));
      @(negedge clk);
      a_sign_load = 1'b0; a_val = 1'b0; a_valid = 1'b1;
      pulses = 0;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         if (k == 0) check("fb first", 32'(measfb), 32'(FB_X));
         if (measfb != FB_INV) pulses++;
      end
      check("fb single pulse", 32'(pulses), 32'd1);
      @(negedge clk);
      a_clear = 1'b1;
      @(posedge clk); #1;
      check("fb clear wins", 32'(measfb), 32'(FB_INV));
      @(negedge clk);
      a_clear = 1'b0;
      @(posedge clk); #1;
      check("fb rearm pulse", 32'(measfb), 32'(FB_X));
      @(posedge clk); #1;
      check("fb rearm single", 32'(measfb), 32'(FB_INV));
      @(negedge clk);
      a_clear = 1'b1;
      @(negedge clk);
      a_clear = 1'b0; a_sign = 1'b0; a_sign_load = 1'b1;
      @(posedge clk); #1;
      check("fb old sign", 32'(measfb), 32'(FB_X));
      @(negedge clk);
      a_sign_load = 1'b0; a_clear = 1'b1;
      @(negedge clk);
      a_clear = 1'b0;
      @(posedge clk); #1;
      check("fb new sign", 32'(measfb), 32'(FB_Z));
      @(negedge clk);
      a_valid = 1'b0;

      // NUM_LQ=5: completed request, then reset mid-SCAN, then a clean request.
      run5("n5_first", 10'h100, 10'h200, 1'b0, 1'b1, 5'h10, 5'h00, 1'b1, 10'h200);
      @(negedge clk);
      lpp5 = 10'h155; bp5 = 10'h2AA; chk5 = 1'b1; upd5 = 1'b1; in_valid5 = 1'b1;
      @(posedge clk); #1;
      in_valid5 = 1'b0;
      @(posedge clk); #2;
      rst5_n = 1'b0;
      #1;
      check("n5 rst in_ready", 32'(in_ready5), 32'd1);
      check("n5 rst out_valid", 32'(out_valid5), 32'd0);
      check("n5 rst final", 32'(final5), 32'd0);
      check("n5 rst bpreg", 32'(bpreg5), 32'd0);
      check("n5 rst measfb", 32'(measfb5), 32'(FB_INV));
      @(negedge clk);
      rst5_n = 1'b1;
      run5("n5_after_rst", 10'h200, 10'h100, 1'b1, 1'b0, 5'h10, 5'h00, 1'b1, 10'h000);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/lmu_interpret_seq.md
Name: lmu_interpret_seq

Overview:
- Sequential, parametrised successor of the combinational LMU interpreter.
- Accepts one logical-measurement request per handshake and scans NUM_LQ logical qubits, LANES per cycle.
- Produces final_meas (Pauli-frame/sign corrected) and maintains the byproduct register internally.
- Emits one-shot measurement feedback (X/Z) from the a-path with its own taken/sign state; sits between the LMU measurement decoder and the feedback/PFU logic.

Parameters:
- NUM_LQ, 8, number of logical qubits; Pauli lists are 2*NUM_LQ bits.
- LANES, 2, qubits examined per SCAN cycle; 1 <= LANES <= NUM_LQ, need not divide NUM_LQ.
- CNT_W, $clog2(NUM_LQ+1), width of the internal anticommute counter.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  high only in IDLE.
- lpplist  input  2*NUM_LQ  measured Pauli product, PP_* encoding from define.v.
- byproduct  input  2*NUM_LQ  byproduct to check against and fold into the register.
- byproduct_check  input  1  include the anticommute parity in final_meas.
- byproduct_upd  input  1  XOR byproduct into byproduct_reg on completion.
- meas_sign  input  1  raw measurement sign.
- init_meas  input  1  initial measurement value.
- lqsignX_acc  input  NUM_LQ  accumulated X signs.
- lqsignZ_acc  input  NUM_LQ  accumulated Z signs.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer ready.
- final_meas  output  1  corrected measurement.
- byproduct_reg  output  2*NUM_LQ  current byproduct frame.
- a_valid  input  1  feedback candidate valid.
- a_val  input  1  feedback value.
- a_sign_load  input  1  load a_sign.
- a_sign  input  1  MEASSIGN_PLUS/MINUS.
- a_clear  input  1  re-arm feedback (clears a_taken).
- measfb_xorz  output  2  FBXORZ_X/Z/INVALID, one-cycle pulse.

Behaviour:
- Reset: in_ready=1; out_valid=0; final_meas=0; byproduct_reg=0; measfb_xorz=FBXORZ_INVALID; a_taken=0; a_sign_reg=MEASSIGN_PLUS; lane counter=0; state=IDLE.
- FSM states: IDLE, SCAN, DONE.
- IDLE: on in_valid&in_ready, capture all request inputs into shadow registers, clear the not_commute and lqsign accumulators, clear the index, go to SCAN. Later input changes have no effect on the in-flight request.
- SCAN: each cycle processes qubits idx..idx+LANES-1; indices >= NUM_LQ are ignored.
  - Per qubit: not_commute ^= (lpp!=bpp & lpp!=PP_I & bpp!=PP_I).
  - lqsign ^= X[i] if lpp==PP_X; Z[i] if PP_Z; X[i]^Z[i] if PP_Y; nothing for PP_I.
  - idx += LANES. When idx+LANES >= NUM_LQ, go to DONE.
- DONE entry cycle:
  - final_meas = (not_commute & byproduct_check) ^ lqsign ^ meas_sign ^ init_meas.
  - out_valid=1.
  - If byproduct_upd, byproduct_reg ^= captured byproduct. The update happens once, on entry, not on handshake.
- DONE hold: final_meas and out_valid are held until out_ready, then out_valid=0 and the FSM returns to IDLE. A new request is accepted no earlier than the cycle after.
- Latency: accept to out_valid = ceil(NUM_LQ/LANES)+1 cycles. Back-to-back throughput is one request per ceil(NUM_LQ/LANES)+2 cycles with out_ready held high.
- The byproduct check uses the captured byproduct input, not byproduct_reg, matching the single-cycle semantics.
- Feedback path runs independently of the FSM:
  - a_sign_load updates a_sign_reg the next cycle.
  - When a_valid & ~a_taken, measfb_xorz is registered as FBXORZ_X if a_val==1 with PLUS or a_val==0 with MINUS, and FBXORZ_Z otherwise; a_taken is set to 1. Otherwise measfb_xorz=FBXORZ_INVALID.
  - a_valid held high therefore yields exactly one pulse.
  - a_clear clears a_taken. If a_clear and a_valid are high in the same cycle, a_clear wins: no pulse that cycle, pulse next cycle if a_valid is still high.
  - a_sign_load coincident with a_valid: the pulse uses the old a_sign_reg.
- Asynchronous reset mid-SCAN or mid-DONE aborts the request. No byproduct update occurs unless DONE was already entered before reset.

Optional Feature:
- Macro LMU_ANTICOMM_CNT_EN.
- Defined: adds output anticomm_cnt [CNT_W-1:0], the number of anticommuting qubits in the last completed request. It is valid with out_valid and reset to 0. The counter saturates at NUM_LQ. not_commute equals anticomm_cnt[0].
- Undefined: no port, no counter logic; behaviour otherwise identical.

Test Plan:
- NUM_LQ=8, LANES=2, all PP_I, meas_sign=1, init_meas=0 -> out_valid at accept+5, final_meas=1.
- lpplist q0=PP_X, byproduct q0=PP_Z, byproduct_check=1, all signs 0 -> final_meas=1; with byproduct_check=0 -> final_meas=0.
- lpplist q3=PP_Y, lqsignX[3]=1, lqsignZ[3]=0, byproduct_upd=1, byproduct q3=PP_X twice -> final_meas=1 both times; byproduct_reg nonzero after the first, back to 0 after the second.
- out_ready held low 10 cycles -> out_valid and final_meas stable, in_ready=0; then a one-cycle out_ready -> in_ready=1 the next cycle.
- a_sign=MINUS loaded, a_valid held high 5 cycles with a_val=0 -> a single FBXORZ_X pulse; a_clear with a_valid high -> no pulse that cycle, one FBXORZ_X pulse the following cycle.
- NUM_LQ=5, LANES=2, rst_n asserted during SCAN -> all outputs at reset values immediately; the following request completes normally at accept+4.
